// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register ahead of the shift register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps

module uart_tx #(
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned CLOCK_FREQ = 50000000,
    parameter int unsigned BAUD_TICK  = CLOCK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    localparam logic [15:0] TICK_LAST = 16'(BAUD_TICK - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_baud_cnt;
    logic [15:0] w_baud_cnt_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_nxt;
    logic [7:0]  r_hold;
    logic        r_hold_full;
    logic        w_hold_full_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        w_baud_done;
    logic        w_accept;
    logic        w_load;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    assign w_baud_done = (r_baud_cnt == TICK_LAST);
    assign w_accept    = valid && !r_hold_full;
    // Every entry into START drains the holding register into the shift register.
    assign w_load      = (w_state_nxt == ST_START) && (r_state != ST_START);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_done && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_done) begin
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_baud_done) begin
                    w_state_nxt = r_hold_full ? ST_START : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_baud_cnt_nxt = r_baud_cnt + 16'd1;
        if ((r_state == ST_IDLE) || (w_state_nxt != r_state) || w_baud_done) begin
            w_baud_cnt_nxt = 16'd0;
        end

        w_bit_idx_nxt = 3'd0;
        if (r_state == ST_DATA) begin
            w_bit_idx_nxt = w_baud_done ? (r_bit_idx + 3'd1) : r_bit_idx;
        end

        w_shift_nxt = r_shift;
        if (w_load) begin
            w_shift_nxt = r_hold;
        end else if ((r_state == ST_DATA) && w_baud_done) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
        end

        w_hold_full_nxt = r_hold_full;
        if (w_load) begin
            w_hold_full_nxt = 1'b0;
        end else if (w_accept) begin
            w_hold_full_nxt = 1'b1;
        end
    end

    // The line level is computed from next-state values and registered so tx never glitches.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            ST_IDLE:   w_tx_nxt = 1'b1;
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_nxt = r_parity;
`endif
            ST_STOP:   w_tx_nxt = 1'b1;
            default:   w_tx_nxt = 1'b1;
        endcase
        busy  = (r_state != ST_IDLE);
        ready = !r_hold_full;
        tx    = r_tx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baud_cnt  <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_hold      <= 8'd0;
            r_hold_full <= 1'b0;
            r_shift     <= 8'd0;
            r_tx        <= 1'b1;
        end else begin
            r_baud_cnt  <= w_baud_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_shift     <= w_shift_nxt;
            r_tx        <= w_tx_nxt;
            if (w_accept) begin
                r_hold <= data;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is latched with the byte so the holding register is free to refill mid-frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^r_hold;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line decoder reconstructs each frame and checks it against bytes queued on acceptance.
// Honours UART_TX_PARITY_EN for the frame shape.
`timescale 1ns/1ps

module tb_uart_tx;
  localparam int BT = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data = 8'd0;
  logic       valid = 1'b0;
  logic       ready;
  logic       busy;
  logic       tx;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         rst_seen = 1'b0;
  logic       last_par = 1'b0;

  uart_tx #(.BAUD_TICK(BT)) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .tx    (tx)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge reset) rst_seen = 1'b1;

  function automatic logic ref_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return logic'(ones % 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: junk on data while ready is low, then the real byte on the accepting edge
  task automatic send(input logic [7:0] b, output int acc);
    int budget = 0;
    @(negedge clk);
    valid = 1'b1;
    while (!ready && budget < 4 * FRAME) begin
      data = 8'($urandom_range(0, 255));
      @(negedge clk);
      budget++;
    end
    check("accept_ready", {31'd0, ready}, 32'd1);
    data = b;
    if (ready) exp_q.push_back(b);
    @(posedge clk);
    #1;
    acc = cyc;
    valid = 1'b0;
    data = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_idle(output int t);
    int budget = 0;
    @(posedge clk);
    @(negedge clk);
    while (busy && budget < 4 * FRAME) begin
      @(negedge clk);
      budget++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    t = cyc;
  endtask

  // monitor: decode the line mid-bit and compare with the scoreboard
  initial begin
    logic       s_start;
    logic       s_stop;
    logic       p;
    logic [7:0] got;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (reset && tx === 1'b0) begin
        rst_seen = 1'b0;
        start_q.push_back(cyc);
        repeat (BT / 2) @(negedge clk);
        s_start = tx;
        for (int k = 0; k < 8; k++) begin
          repeat (BT) @(negedge clk);
          got[k] = tx;
        end
        p = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (BT) @(negedge clk);
        p = tx;
`endif
        repeat (BT) @(negedge clk);
        s_stop = tx;
        if (!rst_seen) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame actual=%0h required=none", got);
          end else begin
            exp = exp_q.pop_front();
            last_par = p;
            check("start_bit", {31'd0, s_start}, 32'd0);
            check("data_byte", {24'd0, got}, {24'd0, exp});
            check("stop_bit", {31'd0, s_stop}, 32'd1);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", {31'd0, p}, {31'd0, ref_parity(exp)});
`endif
          end
        end
      end
    end
  end

  initial begin
    int acc, acc2, t, n0, errs, budget;

    // reset state
    repeat (5) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("post_reset_stable", errs, 0);

    // single byte 0x55
    n0 = start_q.size();
    send(8'h55, acc);
    @(negedge clk);
    check("tx_before_start", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("tx_start_low", {31'd0, tx}, 32'd0);
    wait_idle(t);
    check("single_frames", start_q.size(), n0 + 1);
    if (start_q.size() > n0) check("latency", start_q[n0] - acc, 1);
    check("single_len", t - (acc + 1), FRAME);

    // back-to-back 0xA3, 0x0F with a dropped valid pulse while full
    n0 = start_q.size();
    send(8'hA3, acc);
    repeat (2 * BT) @(negedge clk);
    send(8'h0F, acc2);
    @(negedge clk);
    check("ready_low_when_full", {31'd0, ready}, 32'd0);
    valid = 1'b1;
    repeat (3) begin
      data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    valid = 1'b0;
    budget = 0;
    while (!ready && budget < 2 * FRAME) begin
      @(negedge clk);
      budget++;
    end
    check("ready_rise", cyc, acc + 1 + FRAME);
    wait_idle(t);
    check("b2b_frames", start_q.size(), n0 + 2);
    if (start_q.size() > n0 + 1) check("b2b_gap", start_q[n0 + 1] - start_q[n0], FRAME);
    check("b2b_total", t - (acc + 1), 2 * FRAME);

`ifdef UART_TX_PARITY_EN
    send(8'h07, acc);
    wait_idle(t);
    check("parity_07", {31'd0, last_par}, 32'd1);
    check("parity_len", t - (acc + 1), FRAME);
    send(8'h03, acc);
    wait_idle(t);
    check("parity_03", {31'd0, last_par}, 32'd0);
`endif

    // randomized traffic with random gaps (gap 0 exercises hold-off)
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, FRAME)) @(negedge clk);
      send(8'($urandom_range(0, 255)), acc);
    end
    wait_idle(t);
    check("random_drained", exp_q.size(), 0);

    // reset during bit 3 of 0xFF with a byte pending
    send(8'hFF, acc);
    send(8'h81, acc2);
    budget = 0;
    while (cyc < acc + 1 + 4 * BT + BT / 2 && budget < 2 * FRAME) begin
      @(negedge clk);
      budget++;
    end
    check("midframe_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    errs = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("pending_discarded", errs, 0);

    // final report
    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
